pipeline_writeback: RTL

//  Final (WB) stage of the 5-stage RV32I pipeline: the write-side end of the decode-stage register-file port.

---
 rtl/pipeline_writeback.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/pipeline_writeback.sv
// ============================================================================
// Module      : pipeline_writeback
// Description : RV32I WB stage. It buffers retiring instructions in a 2-entry FIFO,
//               drives the register-file write port, and counts retired instructions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_writeback #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 64
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [6:0]         opcode_i,
  input  logic [2:0]         funct3_i,
  input  logic [RADDR_W-1:0] rd_i,
  input  logic [XLEN-1:0]    alu_result_i,
  input  logic [XLEN-1:0]    mem_rdata_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               stall_i,
  output logic [RADDR_W-1:0] write_reg_o,
  output logic [XLEN-1:0]    write_data_o,
  output logic               reg_write_o,
  output logic               fault_o,
  output logic [CNT_W-1:0]   retired_o
);

  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;

  logic [RADDR_W-1:0] r_rd_q    [2];
  logic [XLEN-1:0]    r_data_q  [2];
  logic               r_we_q    [2];
  logic               r_fault_q [2];
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic [CNT_W-1:0]   r_retired;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;
  logic [XLEN-1:0]    w_data;
  logic               w_we;
  logic               w_fault;

  assign w_empty = (r_count == 2'd0);
  assign ready_o = (r_count != 2'd2);
  assign w_push  = valid_i & ready_o;
  assign w_pop   = !w_empty & !stall_i;

  always_comb begin
    w_byte = mem_rdata_i[7:0];
    case (alu_result_i[1:0])
      2'b01:   w_byte = mem_rdata_i[15:8];
      2'b10:   w_byte = mem_rdata_i[23:16];
      2'b11:   w_byte = mem_rdata_i[31:24];
      default: w_byte = mem_rdata_i[7:0];
    endcase
    w_half = alu_result_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
  end

  // Result is resolved at push time so the FIFO only holds final write data.
  always_comb begin
    w_data  = '0;
    w_we    = 1'b0;
    w_fault = 1'b0;
    case (opcode_i)
      c_OPC_LOAD: begin
        case (funct3_i)
          3'b000: begin w_data = {{(XLEN-8){w_byte[7]}}, w_byte};   w_we = 1'b1; end
          3'b100: begin w_data = {{(XLEN-8){1'b0}}, w_byte};        w_we = 1'b1; end
          3'b001: begin
            w_data = {{(XLEN-16){w_half[15]}}, w_half};
            w_we   = !alu_result_i[0];
            w_fault = alu_result_i[0];
          end
          3'b101: begin
            w_data = {{(XLEN-16){1'b0}}, w_half};
            w_we   = !alu_result_i[0];
            w_fault = alu_result_i[0];
          end
          3'b010: begin
            w_data  = mem_rdata_i;
            w_we    = (alu_result_i[1:0] == 2'b00);
            w_fault = (alu_result_i[1:0] != 2'b00);
          end
          default: w_fault = 1'b1;
        endcase
      end
      c_OPC_JAL, c_OPC_JALR: begin
        w_data = pc_i + XLEN'(4);
        w_we   = 1'b1;
      end
      c_OPC_LUI, c_OPC_AUIPC, c_OPC_OP, c_OPC_OP_IMM: begin
        w_data = alu_result_i;
        w_we   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_count   <= 2'd0;
      r_retired <= '0;
    end else begin
      if (w_push) begin
        r_rd_q[r_wr_ptr]    <= rd_i;
        r_data_q[r_wr_ptr]  <= w_data;
        r_we_q[r_wr_ptr]    <= w_we & (rd_i != '0);
        r_fault_q[r_wr_ptr] <= w_fault;
        r_wr_ptr            <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        if (!r_fault_q[r_rd_ptr]) begin
          r_retired <= r_retired + CNT_W'(1);
        end
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign write_reg_o  = w_empty ? '0 : r_rd_q[r_rd_ptr];
  assign write_data_o = w_empty ? '0 : r_data_q[r_rd_ptr];
  assign reg_write_o  = w_pop & r_we_q[r_rd_ptr];
  assign fault_o      = w_pop & r_fault_q[r_rd_ptr];
  assign retired_o    = r_retired;

endmodule

`default_nettype wire
